// File: rtl/bt_axil_pkg.sv
// Shared definitions for the Bluetooth UART AXI4-Lite register block:
// register offsets, response code, FSM states and byte-merge helper.
package bt_axil_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_TXDATA = 2'd1;
  localparam logic [1:0] ADDR_BAUD   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    HAVE_AW,
    HAVE_W,
    RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bt_axil_wr_fsm.sv
// AXI4-Lite write-channel ordering FSM: accepts AW and W in any order,
// latches whichever arrives first and issues a single commit strobe.
module bt_axil_wr_fsm
  import bt_axil_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   awaddr,
  input  logic            awvalid,
  output logic            awready,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            wvalid,
  output logic            wready,
  output logic            bvalid,
  input  logic            bready,
  output logic            commit,
  output logic [AW-1:0]   commit_addr,
  output logic [DW-1:0]   commit_data,
  output logic [DW/8-1:0] commit_strb
);

  wr_state_t state;
  wr_state_t state_nxt;

  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic [DW/8-1:0] strb_q;
  logic            aw_hs;
  logic            w_hs;

  assign awready = (state == IDLE) || (state == HAVE_W);
  assign wready  = (state == IDLE) || (state == HAVE_AW);
  assign bvalid  = (state == RESP);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      if (aw_hs) addr_q <= awaddr;
      if (w_hs) begin
        data_q <= wdata;
        strb_q <= wstrb;
      end
    end
  end

  // The half that has not been latched yet comes straight off the bus.
  always_comb begin
    state_nxt   = state;
    commit      = 1'b0;
    commit_addr = addr_q;
    commit_data = data_q;
    commit_strb = strb_q;
    unique case (state)
      IDLE: begin
        commit_addr = awaddr;
        commit_data = wdata;
        commit_strb = wstrb;
        if (aw_hs && w_hs) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end else if (aw_hs) begin
          state_nxt = HAVE_AW;
        end else if (w_hs) begin
          state_nxt = HAVE_W;
        end
      end
      HAVE_AW: begin
        commit_data = wdata;
        commit_strb = wstrb;
        if (w_hs) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      HAVE_W: begin
        commit_addr = awaddr;
        if (aw_hs) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/bt_axil_regs.sv
// AXI4-Lite slave register block for the Bluetooth UART (CTRL/TXDATA/BAUD/STATUS).
// Define BT_AXIL_WSTRB_EN to honour per-byte write strobes.
module bt_axil_regs
  import bt_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [31:0]                     ctrl,
  output logic [7:0]                      tx_data,
  output logic                            tx_push,
  output logic [15:0]                     baud_div,
  input  logic [31:0]                     status
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;

  logic            commit;
  logic [AW-1:0]   c_addr;
  logic [DW-1:0]   c_data;
  logic [DW/8-1:0] c_strb;
  logic [3:0]      eff_strb;
  logic [1:0]      c_sel;

  logic [31:0] reg_ctrl;
  logic [31:0] reg_tx;
  logic [31:0] reg_baud;

  bt_axil_wr_fsm #(
    .AW(AW),
    .DW(DW)
  ) u_wr (
    .clk         (s00_axi_aclk),
    .rst         (s00_axi_areset),
    .awaddr      (s00_axi_awaddr),
    .awvalid     (s00_axi_awvalid),
    .awready     (s00_axi_awready),
    .wdata       (s00_axi_wdata),
    .wstrb       (s00_axi_wstrb),
    .wvalid      (s00_axi_wvalid),
    .wready      (s00_axi_wready),
    .bvalid      (s00_axi_bvalid),
    .bready      (s00_axi_bready),
    .commit      (commit),
    .commit_addr (c_addr),
    .commit_data (c_data),
    .commit_strb (c_strb)
  );

  assign c_sel = c_addr[3:2];

`ifdef BT_AXIL_WSTRB_EN
  assign eff_strb = c_strb;
`else
  assign eff_strb = 4'hF;
`endif

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      reg_ctrl <= '0;
      reg_tx   <= '0;
      reg_baud <= '0;
      tx_push  <= 1'b0;
    end else begin
      // A TXDATA write pushes even if no byte lane is enabled.
      tx_push <= commit && (c_sel == ADDR_TXDATA);
      if (commit) begin
        unique case (c_sel)
          ADDR_CTRL:   reg_ctrl <= merge_bytes(reg_ctrl, c_data, eff_strb);
          ADDR_TXDATA: reg_tx   <= merge_bytes(reg_tx, c_data, eff_strb);
          ADDR_BAUD:   reg_baud <= merge_bytes(reg_baud, c_data, eff_strb);
          ADDR_STATUS: ;
        endcase
      end
    end
  end

  assign ctrl          = reg_ctrl;
  assign tx_data       = reg_tx[7:0];
  assign baud_div      = reg_baud[15:0];
  assign s00_axi_bresp = RESP_OKAY;
  assign s00_axi_rresp = RESP_OKAY;

  rd_state_t   rd_state;
  rd_state_t   rd_state_nxt;
  logic        ar_hs;
  logic [31:0] rd_mux;

  assign s00_axi_arready = (rd_state == R_IDLE);
  assign s00_axi_rvalid  = (rd_state == R_DATA);
  assign ar_hs           = s00_axi_arvalid && s00_axi_arready;

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) rd_state <= R_IDLE;
    else                rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    unique case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_nxt = R_DATA;
      R_DATA:  if (s00_axi_rready) rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    unique case (s00_axi_araddr[3:2])
      ADDR_CTRL:   rd_mux = reg_ctrl;
      ADDR_TXDATA: rd_mux = reg_tx;
      ADDR_BAUD:   rd_mux = reg_baud;
      ADDR_STATUS: rd_mux = status;
    endcase
  end

  // Registers sample before any same-edge write lands: read sees the old value.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset)  s00_axi_rdata <= '0;
    else if (ar_hs)      s00_axi_rdata <= rd_mux;
  end

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_araddr[1:0], c_addr[1:0], c_strb};

endmodule

// File: tb/tb_bt_axil_regs.sv
// Self-checking bench for bt_axil_regs: directed protocol cases plus
// randomized traffic checked against a byte-level register model.
module tb_bt_axil_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] ctrl;
  logic [7:0]  tx_data;
  logic        tx_push;
  logic [15:0] baud_div;
  logic [31:0] status;

  int errors = 0;
  int checks = 0;
  int push_cnt = 0;
  int push_exp = 0;

  logic [7:0] mem [4][4];

  always #5 clk = ~clk;

  always @(posedge clk) if (tx_push === 1'b1) push_cnt++;

  bt_axil_regs dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (rst),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .ctrl            (ctrl),
    .tx_data         (tx_data),
    .tx_push         (tx_push),
    .baud_div        (baud_div),
    .status          (status)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++) mem[w][b] = 8'h00;
  endtask

  function automatic logic [31:0] model_rd(input int w);
    if (w == 3) return status;
    return {mem[w][3], mem[w][2], mem[w][1], mem[w][0]};
  endfunction

  task automatic model_wr(input int w, input logic [31:0] d,
                          input logic [3:0] s);
    if (w == 1) push_exp++;
    if (w == 3) return;
    for (int b = 0; b < 4; b++) begin
`ifdef BT_AXIL_WSTRB_EN
      if (s[b]) mem[w][b] = d[8*b +: 8];
`else
      mem[w][b] = d[8*b +: 8];
`endif
    end
  endtask

  task automatic check_outs(input string tag);
    logic [31:0] t;
    logic [31:0] bd;
    t  = model_rd(1);
    bd = model_rd(2);
    check({tag, ".ctrl"}, ctrl, model_rd(0));
    check({tag, ".tx_data"}, {24'h0, tx_data}, {24'h0, t[7:0]});
    check({tag, ".baud_div"}, {16'h0, baud_div}, {16'h0, bd[15:0]});
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int aw_dly,
                           input int w_dly, input int b_dly);
    int cyc;
    bit aw_done;
    bit w_done;
    bit aw_hs;
    bit w_hs;
    int w;
    cyc = 0;
    aw_done = 0;
    w_done = 0;
    w = int'(a[3:2]);
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      if (!aw_done) check("wr.awready", {31'h0, awready}, 32'd1);
      if (!w_done) check("wr.wready", {31'h0, wready}, 32'd1);
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid  = !w_done && cyc >= w_dly;
      aw_hs   = awvalid && awready;
      w_hs    = wvalid && wready;
      @(posedge clk);
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      cyc++;
    end
    check("wr.timeout", {31'h0, aw_done && w_done}, 32'd1);
    if (aw_done && w_done) model_wr(w, d, s);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("wr.bvalid", {31'h0, bvalid}, 32'd1);
    check("wr.bresp", {30'h0, bresp}, 32'd0);
    check("wr.tx_push", {31'h0, tx_push}, {31'h0, w == 1});
    check_outs("wr");
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      check("hold.bvalid", {31'h0, bvalid}, 32'd1);
      check("hold.awready", {31'h0, awready}, 32'd0);
      check("hold.wready", {31'h0, wready}, 32'd0);
      check("hold.tx_push", {31'h0, tx_push}, 32'd0);
    end
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    check("wr.bdone", {31'h0, bvalid}, 32'd0);
    check("wr.awready_back", {31'h0, awready}, 32'd1);
  endtask

  task automatic axi_read(input logic [3:0] a, input int r_dly);
    logic [31:0] exp;
    @(negedge clk);
    check("rd.arready", {31'h0, arready}, 32'd1);
    arvalid = 1'b1;
    araddr  = a;
    exp     = model_rd(int'(a[3:2]));
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    check("rd.rvalid", {31'h0, rvalid}, 32'd1);
    check("rd.rdata", rdata, exp);
    check("rd.rresp", {30'h0, rresp}, 32'd0);
    check("rd.arready_busy", {31'h0, arready}, 32'd0);
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      check("rd.hold_rvalid", {31'h0, rvalid}, 32'd1);
      check("rd.hold_rdata", rdata, exp);
    end
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
    check("rd.rdone", {31'h0, rvalid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    status = 32'h0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst.awready", {31'h0, awready}, 32'd1);
    check("rst.wready", {31'h0, wready}, 32'd1);
    check("rst.arready", {31'h0, arready}, 32'd1);
    check("rst.bvalid", {31'h0, bvalid}, 32'd0);
    check("rst.rvalid", {31'h0, rvalid}, 32'd0);
    check("rst.resp", {28'h0, bresp, rresp}, 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.tx_push", {31'h0, tx_push}, 32'd0);
    check_outs("rst");
    rst = 1'b0;

    // Basic map: four writes then four reads
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'h2, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'h3, 4'hF, 0, 0, 0);
    axi_write(4'hC, 32'h4, 4'hF, 0, 0, 0);
    status = 32'hA5A5_0000;
    axi_read(4'h0, 0);
    check("map.ctrl", rdata, 32'h1);
    axi_read(4'h4, 0);
    check("map.txdata", rdata, 32'h2);
    axi_read(4'h8, 1);
    check("map.baud", rdata, 32'h3);
    axi_read(4'hC, 0);
    check("map.status", rdata, 32'hA5A5_0000);
    check("map.push_once", push_cnt, 32'd1);

    // W before AW, then AW before W
    axi_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 0, 0);
    check("wfirst.baud", {16'h0, baud_div}, 32'h0000BEEF);
    axi_write(4'h8, 32'h0, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'hDEADBEEF, 4'hF, 0, 3, 0);
    check("awfirst.baud", {16'h0, baud_div}, 32'h0000BEEF);

    // Response back-pressure
    axi_write(4'h0, 32'h5, 4'hF, 0, 0, 5);

    // Byte strobes
    axi_write(4'h0, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(4'h0, 32'hAABBCCDD, 4'b0101, 1, 0, 0);
`ifdef BT_AXIL_WSTRB_EN
    check("strb.ctrl", ctrl, 32'h11BB33DD);
`else
    check("strb.ctrl", ctrl, 32'hAABBCCDD);
`endif
    axi_write(4'h4, 32'h77, 4'h0, 0, 0, 0);

    // Same-cycle read and write to TXDATA
    axi_write(4'h4, 32'h12, 4'hF, 0, 0, 0);
    @(negedge clk);
    awvalid = 1'b1; awaddr = 4'h4;
    wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 4'h4;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model_wr(1, 32'h55, 4'hF);
    check("rw.rvalid", {31'h0, rvalid}, 32'd1);
    check("rw.rdata_old", rdata, 32'h12);
    check("rw.bvalid", {31'h0, bvalid}, 32'd1);
    check("rw.tx_data", {24'h0, tx_data}, 32'h55);
    check("rw.tx_push", {31'h0, tx_push}, 32'd1);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    check("rw.done", {30'h0, bvalid, rvalid}, 32'd0);
    axi_read(4'h4, 0);
    check("rw.rdata_new", rdata, 32'h55);

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      logic [3:0] a;
      a = {$urandom_range(0, 3) == 0 ? 2'd3 : 2'($urandom_range(0, 2)), 2'b00};
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2));
      end else begin
        status = $urandom;
        axi_read(a, $urandom_range(0, 2));
      end
    end
    check("push_count", push_cnt, push_exp);

    // Reset while holding an address
    axi_write(4'h0, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    @(negedge clk);
    awvalid = 1'b1; awaddr = 4'h4;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    check("mid.awready", {31'h0, awready}, 32'd0);
    #2 rst = 1'b1;
    #1 check("mid.async_awready", {31'h0, awready}, 32'd1);
    check("mid.async_ctrl", ctrl, 32'd0);
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post.bvalid", {31'h0, bvalid}, 32'd0);
      check("post.awready", {31'h0, awready}, 32'd1);
    end
    check_outs("post");
    status = 32'h0BAD_F00D;
    for (int w = 0; w < 4; w++) axi_read(4'(w * 4), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bt_axil_regs.md
# bt_axil_regs

AXI4-Lite slave register block for the Bluetooth UART peripheral: the responder end of the 32-bit AXI4-Lite bus driven by the PS/VIP master. It decodes four word registers and accepts write address and write data in any order. It returns OKAY responses and exposes the register contents and a TX push strobe to the Bluetooth UART core.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: address width; bits [3:2] select the register.
- s00_axi_aclk  in  1  sole clock; all logic is on the rising edge.
- s00_axi_areset  in  1  reset, asynchronous and active-high.
- s00_axi_awaddr / awprot / awvalid / awready  in/in/in/out  4/3/1/1  write address channel; awprot is ignored.
- s00_axi_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response channel.
- s00_axi_araddr / arprot / arvalid / arready  in/in/in/out  4/3/1/1  read address channel.
- s00_axi_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data channel.
- ctrl  out  32  REG0 contents: bit0 = UART enable, bit1 = loopback.
- tx_data  out  8  REG1[7:0].
- tx_push  out  1  one-cycle pulse when REG1 is written.
- baud_div  out  16  REG2[15:0].
- status  in  32  value returned on reads of REG3.

## Operation
- Register map: 0x0 CTRL (RW), 0x4 TXDATA (RW), 0x8 BAUD (RW), 0xC STATUS (RO). Writes to 0xC complete with OKAY and have no effect.
- Write path states: IDLE, HAVE_AW, HAVE_W, RESP.
  - IDLE: awready = wready = 1.
  - AW handshake only → HAVE_AW; the address is latched and awready drops.
  - W handshake only → HAVE_W; data and strobe are latched and wready drops.
  - Both handshakes in the same cycle → commit.
  - HAVE_AW + W handshake → commit. HAVE_W + AW handshake → commit.
  - Commit: the register updates at that edge, bvalid = 1 and state goes to RESP.
  - RESP: awready = wready = 0; bvalid holds until bready, then → IDLE.
- Read path states: R_IDLE (arready = 1) and R_DATA (arready = 0).
  - AR handshake: rdata is loaded from the addressed register value before that edge, rvalid = 1, → R_DATA.
  - rvalid, rdata and rresp stay stable until rready, then → R_IDLE.
- bresp and rresp are always 2'b00 (OKAY).
- tx_push pulses for the one cycle after the commit edge of a write to 0x4, including writes with wstrb = 0.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- Read and write paths are independent and may be busy at the same time.

## Timing
- Reset values: awready = wready = arready = 1; bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0; all registers = 0; tx_push = 0.
- Reset asserted mid-transaction aborts it. No response is issued and registers clear.
- Write latency: bvalid is high the cycle after the later of the AW and W handshakes.
- Read latency: rvalid is high the cycle after the AR handshake.
- Maximum throughput: one write every 2 cycles with bready tied high; one read every 2 cycles with rready tied high.
- The ctrl, tx_data and baud_div outputs reflect a write in the cycle after commit.

## Configuration
- BT_AXIL_WSTRB_EN defined: each wstrb[n] enables byte n of the write; cleared strobe bytes keep their old value.
- BT_AXIL_WSTRB_EN undefined: wstrb is ignored and every write replaces the full 32-bit word.

## Structure
- Package bt_axil_pkg holds:
  - register offsets: ADDR_CTRL, ADDR_TXDATA, ADDR_BAUD, ADDR_STATUS;
  - the RESP_OKAY constant;
  - the write-FSM and read-FSM state enums.
- Sub-module bt_axil_wr_fsm holds the AW/W ordering FSM and its address/data latches. The read path and the register file remain in the top module.

## Test plan
- After reset, write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC, then read all four with status = 0xA5A5_0000. Reads return 0x1, 0x2, 0x3, 0xA5A5_0000. Every bresp and rresp is 0. tx_push pulses exactly once.
- Present W (0xDEADBEEF) 3 cycles before AW (0x8) → awready drops in neither case early, commit occurs on the AW handshake, and baud_div = 0xBEEF the cycle after. Repeat with AW first and expect the same result.
- Hold bready = 0 for 5 cycles after a write → bvalid stays 1; awready and wready stay 0; a second AW is not accepted until the cycle after bready.
- With BT_AXIL_WSTRB_EN: CTRL = 0x11223344, then write 0xAABBCCDD with wstrb = 4'b0101 → CTRL = 0x11BB33DD. Without the macro → CTRL = 0xAABBCCDD.
- Issue a read of 0x4 in the same cycle as a write commit of 0x55 to 0x4 (old value 0x12) → rdata = 0x12; a subsequent read returns 0x55.
- Assert reset while in HAVE_AW → no bvalid is produced; awready = 1 and all registers = 0 after release.
